lut_v_scheduler: RTL and testbench
==================================

# lut_v_scheduler

Sequencer that owns the single `lut_v_module` instance in the AV1 arithmetic-encoder front end and time-multiplexes it between the two per-symbol range lookups: the minimum-probability offset for symbol `s` (upper bound) and for symbol `s-1` (lower bound). It accepts one symbol request at a time over a valid/ready handshake, drives the LUT address in two or fewer sequenced cycles, and presents both offsets, the symbol, and an error flag to the range-update stage over a second valid/ready handshake.

## Interface
- `NSYM_W`, default 5: width of `in_nsyms`; legal values are 1..16.
- `SYM_W`, default 4: width of `in_symbol`.
- `DATA_WIDTH`, default 16: width of LUT data and offsets.
- `CNT_W`, default 16: width of the accepted-symbol counter.

- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  scheduler can accept a request.
- `in_symbol`  in  SYM_W  symbol index `s`.
- `in_nsyms`  in  NSYM_W  alphabet size `N`.
- `lut_addr`  out  8  address to the `lut_v_module`.
- `lut_q`  in  DATA_WIDTH  combinational LUT data for `lut_addr`.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer accepts the result.
- `out_v_cur`  out  DATA_WIDTH  LUT value for `{N-1, s}`.
- `out_v_prev`  out  DATA_WIDTH  LUT value for `{N-1, s-1}`; 0 when `s==0`.
- `out_symbol`  out  SYM_W  registered `s`.
- `out_first`  out  1  set when `s==0`.
- `out_err`  out  1  set for an illegal request.
- `sym_count`  out  CNT_W  number of accepted requests.

## Operation
- Address format: `lut_addr = {N-1[3:0], sym[3:0]}`. The LUT returns `4*((N-1)-sym)` when `sym < N-1`, otherwise 0.
- FSM states: IDLE, LOOK_PREV, LOOK_CUR, OUT.
- **IDLE**
  - `in_ready=1`. On `in_valid`, latch `s`, `N`, and the error check, and increment `sym_count` (wraps modulo 2^CNT_W).
  - Next state: OUT if the request is illegal; LOOK_CUR if `s==0`; LOOK_PREV otherwise.
- Illegal request: `N==0`, `N>16`, or `s>=N`.
  - `out_err=1` and both offsets are 0. No LUT lookup is issued.
- **LOOK_PREV**: `lut_addr={N-1, s-1}`. Register `lut_q` into `out_v_prev` at the end of the cycle. Next state: LOOK_CUR.
- **LOOK_CUR**: `lut_addr={N-1, s}`. Register `lut_q` into `out_v_cur`. Next state: OUT.
- **OUT**
  - `out_valid=1`; all `out_*` signals are held stable.
  - On `out_ready`, go to IDLE.
  - `out_valid` is never withdrawn without `out_ready`.
- `lut_addr` is 8'd0 in IDLE and OUT.
- When `s==0`, `out_v_prev` is cleared to 0 at acceptance. `out_v_prev` and `out_v_cur` are also cleared to 0 at acceptance of an illegal request.
- `in_ready` is 0 in every state except IDLE; at most one request is in flight.
- Flags `out_err` and `out_first` are latched at acceptance.

## Timing
- Reset values, asserted in the cycle after `reset` is sampled high:
  - State IDLE.
  - `in_ready=1`, `out_valid=0`.
  - `lut_addr=0`.
  - `out_v_cur=0`, `out_v_prev=0`, `out_symbol=0`, `out_first=0`, `out_err=0`.
  - `sym_count=0`.
- Reset mid-operation (any state) aborts the in-flight symbol. No output handshake occurs for it, and it is not counted again.
- Latency, from the acceptance edge (cycle T) to `out_valid` high:
  - `s>0`: `out_valid` high in T+3 (LOOK_PREV in T+1, LOOK_CUR in T+2, OUT in T+3).
  - `s==0`: `out_valid` high in T+2.
  - Illegal request: `out_valid` high in T+1.
- Output handshake at edge U: IDLE in U+1, so `in_ready=1` in U+1. No same-cycle acceptance in OUT.
- Minimum throughput: one symbol per 4 cycles for `s>0`, one per 2 for an illegal request.
- `lut_q` is consumed in the same cycle that `lut_addr` is driven (purely combinational path through the LUT).
- `reset` has priority over all handshakes in the same cycle.

## Test plan
- Accept `N=4, s=2`:
  - LOOK_PREV drives `lut_addr=49`; LOOK_CUR drives `lut_addr=50`.
  - Response: `out_v_prev=8`, `out_v_cur=4`, `out_first=0`, `out_err=0`, with `out_valid` in T+3.
- Accept `N=16, s=0`:
  - Single lookup at `lut_addr=240`.
  - Response: `out_v_cur=60`, `out_v_prev=0`, `out_first=1`, with `out_valid` in T+2.
- Accept `N=1, s=0`:
  - `lut_addr=0`.
  - Response: `out_v_cur=0`, `out_v_prev=0`, `out_err=0`.
- Illegal requests `N=4, s=5`, then `N=0, s=0`:
  - Each produces `out_err=1` with both offsets 0 and `out_valid` in T+1.
  - `lut_addr` stays 0 throughout.
  - `sym_count` increments by 2.
- Hold `out_ready=0` for 10 cycles with `N=8, s=3` (addresses 114/115, values 20/16):
  - Outputs stay stable and `in_ready=0`.
  - After `out_ready` is raised, `in_ready=1` one cycle later.
- Assert `reset` during LOOK_CUR:
  - Next cycle shows the reset values on all outputs.
  - No `out_valid` appears for the aborted symbol.
  - A following request `N=2, s=1` (addresses 16/17, values 4/0) completes normally.
  - `sym_count=1` after that request.

Source files
------------

// File: rtl/lut_v_scheduler.sv
// Sequencer that time-multiplexes one lut_v_module between the s-1 (lower
// bound) and s (upper bound) offset lookups of each symbol request.
module lut_v_scheduler #(
  parameter int NSYM_W     = 5,
  parameter int SYM_W      = 4,
  parameter int DATA_WIDTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SYM_W-1:0]      in_symbol,
  input  logic [NSYM_W-1:0]     in_nsyms,
  output logic [7:0]            lut_addr,
  input  logic [DATA_WIDTH-1:0] lut_q,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_v_cur,
  output logic [DATA_WIDTH-1:0] out_v_prev,
  output logic [SYM_W-1:0]      out_symbol,
  output logic                  out_first,
  output logic                  out_err,
  output logic [CNT_W-1:0]      sym_count
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; out_valid stays high with stable out_* until out_ready is seen,
  // and in_ready is high only in IDLE, so at most one request is in flight.

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOOK_PREV = 2'd1,
    LOOK_CUR  = 2'd2,
    OUT       = 2'd3
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic [3:0] nm1_q;
  logic       illegal;
  logic       sym_zero;
  logic       accept;
  logic [3:0] sym_cur;
  logic [3:0] sym_prev;

  always_comb begin
    illegal  = (in_nsyms == '0) || (32'(in_nsyms) > 32'd16) ||
               (32'(in_symbol) >= 32'(in_nsyms));
    sym_zero = (in_symbol == '0);
    accept   = (state_q == IDLE) && in_valid;
    sym_cur  = 4'(out_symbol);
    sym_prev = 4'(out_symbol - SYM_W'(1));
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    lut_addr  = 8'd0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (illegal)       state_d = OUT;
          else if (sym_zero) state_d = LOOK_CUR;
          else               state_d = LOOK_PREV;
        end
      end
      LOOK_PREV: begin
        lut_addr = {nm1_q, sym_prev};
        state_d  = LOOK_CUR;
      end
      LOOK_CUR: begin
        lut_addr = {nm1_q, sym_cur};
        state_d  = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      nm1_q      <= 4'd0;
      out_v_cur  <= '0;
      out_v_prev <= '0;
      out_symbol <= '0;
      out_first  <= 1'b0;
      out_err    <= 1'b0;
      sym_count  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        // Offsets start at zero so s==0 and illegal requests report 0 for
        // any lookup they skip.
        nm1_q      <= 4'(in_nsyms - NSYM_W'(1));
        out_symbol <= in_symbol;
        out_first  <= sym_zero;
        out_err    <= illegal;
        out_v_prev <= '0;
        out_v_cur  <= '0;
        sym_count  <= sym_count + CNT_W'(1);
      end
      if (state_q == LOOK_PREV) out_v_prev <= lut_q;
      if (state_q == LOOK_CUR)  out_v_cur  <= lut_q;
    end
  end

endmodule

// File: tb/tb_lut_v_scheduler.sv
// Scoreboard bench for lut_v_scheduler: a transaction-level model predicts
// per-cycle control behaviour and the result of every accepted request.
module tb_lut_v_scheduler;

  localparam int DW = 16;
  localparam int SW = 4;
  localparam int RW = 2 * DW + SW + 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [SW-1:0] in_symbol;
  logic [4:0]    in_nsyms;
  logic [7:0]    lut_addr;
  logic [DW-1:0] lut_q;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_v_cur;
  logic [DW-1:0] out_v_prev;
  logic [SW-1:0] out_symbol;
  logic          out_first;
  logic          out_err;
  logic [15:0]   sym_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [RW-1:0] exp_q[$];
  int            addr_q[$];
  logic          m_idle     = 1'b1;
  logic          m_out      = 1'b0;
  logic          m_post_rst = 1'b0;
  logic          armed      = 1'b0;
  logic [15:0]   m_cnt      = '0;
  logic          rdy_rand   = 1'b0;

  lut_v_scheduler dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_symbol  (in_symbol),
    .in_nsyms   (in_nsyms),
    .lut_addr   (lut_addr),
    .lut_q      (lut_q),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_v_cur  (out_v_cur),
    .out_v_prev (out_v_prev),
    .out_symbol (out_symbol),
    .out_first  (out_first),
    .out_err    (out_err),
    .sym_count  (sym_count)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // LUT behavioural model: 4*((N-1)-sym) when sym < N-1, else 0
  always_comb begin
    if (lut_addr[3:0] < lut_addr[7:4])
      lut_q = DW'(4 * (int'(lut_addr[7:4]) - int'(lut_addr[3:0])));
    else
      lut_q = '0;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic is_illegal(input int n, input int s);
    return (n == 0) || (n > 16) || (s >= n);
  endfunction

  // Expected result {v_cur, v_prev, symbol, first, err} from the offset rules.
  function automatic logic [RW-1:0] expect_result(input int n, input int s);
    int cur, prev;
    logic err;
    err = is_illegal(n, s);
    cur = 0;
    prev = 0;
    if (!err) begin
      cur  = (s < n - 1) ? 4 * ((n - 1) - s) : 0;
      prev = (s == 0) ? 0 : 4 * ((n - 1) - (s - 1));
    end
    return {DW'(cur), DW'(prev), SW'(s), (s == 0), err};
  endfunction

  // Per-cycle checker and monitor; model advances after each comparison.
  always @(negedge clk) begin
    if (armed) begin
      check("in_ready", 64'(in_ready), 64'(m_idle));
      check("out_valid", 64'(out_valid), 64'(m_out));
      check("lut_addr", 64'(lut_addr), (addr_q.size() > 0) ? 64'(addr_q[0]) : 64'd0);
      check("sym_count", 64'(sym_count), 64'(m_cnt));
      if (m_post_rst) begin
        check("rst_v_cur", 64'(out_v_cur), 64'd0);
        check("rst_v_prev", 64'(out_v_prev), 64'd0);
        check("rst_symbol", 64'(out_symbol), 64'd0);
        check("rst_first", 64'(out_first), 64'd0);
        check("rst_err", 64'(out_err), 64'd0);
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", 64'(out_valid), 64'd0);
        end else begin
          check("v_cur", 64'(out_v_cur), 64'(exp_q[0][RW-1 -: DW]));
          check("v_prev", 64'(out_v_prev), 64'(exp_q[0][RW-DW-1 -: DW]));
          check("symbol", 64'(out_symbol), 64'(exp_q[0][SW+1:2]));
          check("first", 64'(out_first), 64'(exp_q[0][1]));
          check("err", 64'(out_err), 64'(exp_q[0][0]));
          if (out_ready && !reset) void'(exp_q.pop_front());
        end
      end
    end
    if (reset) begin
      m_idle     = 1'b1;
      m_out      = 1'b0;
      m_cnt      = '0;
      m_post_rst = 1'b1;
      armed      = 1'b1;
      addr_q.delete();
    end else if (armed) begin
      m_post_rst = 1'b0;
      if (m_idle) begin
        if (in_valid) begin
          int n, s;
          n = int'(in_nsyms);
          s = int'(in_symbol);
          m_idle = 1'b0;
          m_cnt  = m_cnt + 16'd1;
          if (!is_illegal(n, s)) begin
            if (s > 0) addr_q.push_back((n - 1) * 16 + (s - 1));
            addr_q.push_back((n - 1) * 16 + s);
          end
          if (addr_q.size() == 0) m_out = 1'b1;
        end
      end else if (addr_q.size() > 0) begin
        void'(addr_q.pop_front());
        if (addr_q.size() == 0) m_out = 1'b1;
      end else if (m_out && out_ready) begin
        m_out  = 1'b0;
        m_idle = 1'b1;
      end
    end
  end

  // Random consumer back-pressure when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Driver: present a request, push its expected result on acceptance.
  task automatic send(input int n, input int s);
    int waited;
    waited = 0;
    in_nsyms  = 5'(n);
    in_symbol = SW'(s);
    in_valid  = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready && !reset) begin
        exp_q.push_back(expect_result(n, s));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
      waited++;
      if (waited > 60) begin
        check("accept_timeout", 64'(waited), 64'd0);
        in_valid = 1'b0;
        return;
      end
    end
  endtask

  task automatic wait_drain(input int budget);
    int cyc;
    cyc = 0;
    while ((exp_q.size() != 0 || !m_idle) && cyc < budget) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    check("drain_pending", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_symbol = '0;
    in_nsyms  = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Directed: normal, s==0, N==1 and illegal requests
    send(4, 2);
    send(16, 0);
    send(1, 0);
    send(4, 5);
    send(0, 0);
    wait_drain(50);

    // Back-pressure: hold out_ready low well past out_valid
    out_ready = 1'b0;
    send(8, 3);
    repeat (14) @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_drain(20);
    repeat (2) @(posedge clk);
    #1;

    // Reset during LOOK_CUR aborts the in-flight symbol
    send(8, 3);
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    send(2, 1);
    wait_drain(20);
    check("count_after_reset", 64'(sym_count), 64'd1);

    // Randomized requests with random consumer stalls
    rdy_rand = 1'b1;
    for (int i = 0; i < 200; i++) begin
      int n, s;
      if ($urandom_range(0, 3) != 0) begin
        n = $urandom_range(1, 16);
        s = $urandom_range(0, n - 1);
      end else begin
        n = $urandom_range(0, 31);
        s = $urandom_range(0, 15);
      end
      send(n, s);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    wait_drain(200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
